// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Brief    : Shared constants and types for the two-master bus arbiter:
//            address-region codes, arbiter state encoding and read-return tag.
// Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Region codes taken from address bits [31:29]
  localparam logic [2:0] REGION_CODE  = 3'b000;
  localparam logic [2:0] REGION_BSMEM = 3'b001;
  localparam logic [2:0] REGION_UART  = 3'b010;

  // Hold counter saturation value (4-bit counter)
  localparam logic [3:0] HOLD_SAT = 4'd15;

  // Arbiter ownership state, explicitly encoded
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  // Captured on acceptance; steers the read return one cycle later
  typedef struct packed {
    logic       is_read;
    logic       master;
    logic [2:0] region;
  } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/bus_region_dec.sv
`default_nettype none
// ============================================================================
// Module   : bus_region_dec
// Brief    : Combinational region code -> one-hot slave select decode.
//            Unmapped regions decode to all zeros.
// Revision : 1.0 - initial release
// ============================================================================
module bus_region_dec
  import bus_pkg::*;
(
  input  logic [2:0] i_region,
  output logic [2:0] o_sel
);

  // One-hot decode of the three mapped regions
  always_comb begin
    o_sel = 3'b000;
    case (i_region)
      REGION_CODE:  o_sel = 3'b001;
      REGION_BSMEM: o_sel = 3'b010;
      REGION_UART:  o_sel = 3'b100;
      default:      o_sel = 3'b000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Brief    : Two-master (cpu m0 / dma m1) single-slave bus arbiter with
//            combinational grant, hold-count fairness, lock support, region
//            decode and one-cycle registered read return.
//            Optional macro BUS_ARB_ROUND_ROBIN_EN: an IDLE tie goes to the
//            master not served last (otherwise an IDLE tie always goes to m0).
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
)(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        m0_enable_i,
  input  logic [3:0]  m0_wstrb_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wvalue_i,
  input  logic        m0_lock_i,
  output logic        m0_ready_o,
  output logic [31:0] m0_rvalue_o,
  output logic        m0_rvalid_o,
  input  logic        m1_enable_i,
  input  logic [3:0]  m1_wstrb_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wvalue_i,
  input  logic        m1_lock_i,
  output logic        m1_ready_o,
  output logic [31:0] m1_rvalue_o,
  output logic        m1_rvalid_o,
  output logic        s_enable_o,
  output logic [3:0]  s_wstrb_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wvalue_o,
  output logic [31:0] s_addr_prev_o,
  output logic [2:0]  s_sel_o,
  input  logic [31:0] s0_rvalue_i,
  input  logic [31:0] s1_rvalue_i,
  input  logic [31:0] s2_rvalue_i
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_hold;
  logic        r_lock;
  rd_tag_t     r_tag;
  logic [31:0] r_addr_prev;
`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic        r_last;
`endif

  logic        w_req0;
  logic        w_req1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_acc;
  logic        w_hold_ok;
  logic [2:0]  w_sel;
  logic [31:0] w_rdata;

  // Requests are ignored while reset is asserted so no grant leaks out
  assign w_req0    = m0_enable_i & rstn_i;
  assign w_req1    = m1_enable_i & rstn_i;
  assign w_hold_ok = r_lock || (r_hold < HOLD_LIM);
  assign w_acc     = w_gnt0 | w_gnt1;

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state: the master accepted this cycle becomes the owner
  always_comb begin
    w_state_nxt = ST_IDLE;
    if (w_gnt0)      w_state_nxt = ST_OWN0;
    else if (w_gnt1) w_state_nxt = ST_OWN1;
  end

  // Grant decision: single requester wins at once; contention resolved by owner/lock/hold
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_req0 && w_req1) begin
      case (r_state)
        ST_OWN0: begin
          w_gnt0 = w_hold_ok;
          w_gnt1 = ~w_hold_ok;
        end
        ST_OWN1: begin
          w_gnt1 = w_hold_ok;
          w_gnt0 = ~w_hold_ok;
        end
        default: begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
          w_gnt0 = r_last;
          w_gnt1 = ~r_last;
`else
          w_gnt0 = 1'b1;
`endif
        end
      endcase
    end else begin
      w_gnt0 = w_req0;
      w_gnt1 = w_req1;
    end
  end

  // Slave-side forwarding; m0 is presented whenever m1 is not granted
  assign s_enable_o = w_acc;
  assign s_addr_o   = w_gnt1 ? m1_addr_i   : m0_addr_i;
  assign s_wstrb_o  = w_gnt1 ? m1_wstrb_i  : m0_wstrb_i;
  assign s_wvalue_o = w_gnt1 ? m1_wvalue_i : m0_wvalue_i;
  assign m0_ready_o = w_gnt0;
  assign m1_ready_o = w_gnt1;

  bus_region_dec u_dec (
    .i_region (s_addr_o[31:29]),
    .o_sel    (w_sel)
  );

  assign s_sel_o = w_acc ? w_sel : 3'b000;

  // Hold counter and lock flag track consecutive accepted cycles of the owner
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_hold <= 4'd0;
      r_lock <= 1'b0;
    end else if (w_gnt0) begin
      r_hold <= (r_state != ST_OWN0) ? 4'd1 : (r_hold == HOLD_SAT) ? r_hold : r_hold + 4'd1;
      r_lock <= m0_lock_i;
    end else if (w_gnt1) begin
      r_hold <= (r_state != ST_OWN1) ? 4'd1 : (r_hold == HOLD_SAT) ? r_hold : r_hold + 4'd1;
      r_lock <= m1_lock_i;
    end else begin
      r_hold <= 4'd0;
      r_lock <= 1'b0;
    end
  end

`ifdef BUS_ARB_ROUND_ROBIN_EN
  // Remember which master was served most recently for IDLE tie-breaks
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)    r_last <= 1'b0;
    else if (w_acc) r_last <= w_gnt1;
  end
`endif

  // Read tag capture and slave address history
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_tag       <= '0;
      r_addr_prev <= 32'd0;
    end else begin
      r_tag.is_read <= w_acc && (s_wstrb_o == 4'b0000);
      r_tag.master  <= w_gnt1;
      r_tag.region  <= s_addr_o[31:29];
      r_addr_prev   <= s_addr_o;
    end
  end

  assign s_addr_prev_o = r_addr_prev;

  // Read data select by the tagged region; unmapped regions return zero
  always_comb begin
    w_rdata = 32'd0;
    case (r_tag.region)
      REGION_CODE:  w_rdata = s0_rvalue_i;
      REGION_BSMEM: w_rdata = s1_rvalue_i;
      REGION_UART:  w_rdata = s2_rvalue_i;
      default:      w_rdata = 32'd0;
    endcase
  end

  assign m0_rvalid_o = r_tag.is_read & ~r_tag.master;
  assign m1_rvalid_o = r_tag.is_read &  r_tag.master;
  assign m0_rvalue_o = m0_rvalid_o ? w_rdata : 32'd0;
  assign m1_rvalue_o = m1_rvalid_o ? w_rdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Directed self-checking bench for bus_arbiter (HOLD_MAX = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        m0_enable_i, m1_enable_i, m0_lock_i, m1_lock_i;
  logic [3:0]  m0_wstrb_i, m1_wstrb_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wvalue_i, m1_wvalue_i;
  logic        m0_ready_o, m1_ready_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rvalue_o, m1_rvalue_o;
  logic        s_enable_o;
  logic [3:0]  s_wstrb_o;
  logic [31:0] s_addr_o, s_wvalue_o, s_addr_prev_o;
  logic [2:0]  s_sel_o;
  logic [31:0] s0_rvalue_i, s1_rvalue_i, s2_rvalue_i;

  int n_checks = 0;
  int n_fail   = 0;
  logic first;
  logic exp1;

  bus_arbiter #(.HOLD_MAX(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .m0_enable_i(m0_enable_i), .m0_wstrb_i(m0_wstrb_i), .m0_addr_i(m0_addr_i),
    .m0_wvalue_i(m0_wvalue_i), .m0_lock_i(m0_lock_i), .m0_ready_o(m0_ready_o),
    .m0_rvalue_o(m0_rvalue_o), .m0_rvalid_o(m0_rvalid_o),
    .m1_enable_i(m1_enable_i), .m1_wstrb_i(m1_wstrb_i), .m1_addr_i(m1_addr_i),
    .m1_wvalue_i(m1_wvalue_i), .m1_lock_i(m1_lock_i), .m1_ready_o(m1_ready_o),
    .m1_rvalue_o(m1_rvalue_o), .m1_rvalid_o(m1_rvalid_o),
    .s_enable_o(s_enable_o), .s_wstrb_o(s_wstrb_o), .s_addr_o(s_addr_o),
    .s_wvalue_o(s_wvalue_o), .s_addr_prev_o(s_addr_prev_o), .s_sel_o(s_sel_o),
    .s0_rvalue_i(s0_rvalue_i), .s1_rvalue_i(s1_rvalue_i), .s2_rvalue_i(s2_rvalue_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic e0, input logic [3:0] ws0, input logic [31:0] a0, input logic l0,
                     input logic e1, input logic [3:0] ws1, input logic [31:0] a1, input logic l1);
    m0_enable_i = e0; m0_wstrb_i = ws0; m0_addr_i = a0; m0_lock_i = l0;
    m1_enable_i = e1; m1_wstrb_i = ws1; m1_addr_i = a1; m1_lock_i = l1;
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    s0_rvalue_i = 32'h1111_0000;
    s1_rvalue_i = 32'hDEAD_BEEF;
    s2_rvalue_i = 32'h2222_0002;
    m0_wvalue_i = 32'hA0A0_A0A0;
    m1_wvalue_i = 32'hB1B1_B1B1;
    rstn_i = 1'b0;
    drv(1'b1, 4'h0, 32'h2000_0010, 1'b0, 1'b1, 4'h0, 32'h0000_0000, 1'b0);

    // Reset state with both masters requesting
    cyc(); cyc(); #1;
    chk("rst_m0_ready", m0_ready_o, 0);
    chk("rst_m1_ready", m1_ready_o, 0);
    chk("rst_s_enable", s_enable_o, 0);
    chk("rst_s_sel", s_sel_o, 0);
    chk("rst_rvalid", {m0_rvalid_o, m1_rvalid_o}, 0);
    chk("rst_addr_prev", s_addr_prev_o, 0);
    drv(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    rstn_i = 1'b1;

    // m0 read of bsmem region
    cyc(); drv(1'b1, 4'h0, 32'h2000_0010, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0); #1;
    chk("rd0_m0_ready", m0_ready_o, 1);
    chk("rd0_m1_ready", m1_ready_o, 0);
    chk("rd0_s_enable", s_enable_o, 1);
    chk("rd0_s_sel", s_sel_o, 3'b010);
    chk("rd0_s_addr", s_addr_o, 32'h2000_0010);

    // m1 read of unmapped region; m0 read data returns
    cyc(); drv(1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h6000_0000, 1'b0); #1;
    chk("rd0_m0_rvalid", m0_rvalid_o, 1);
    chk("rd0_m0_rvalue", m0_rvalue_o, 32'hDEAD_BEEF);
    chk("rd0_m1_rvalid", m1_rvalid_o, 0);
    chk("rd0_addr_prev", s_addr_prev_o, 32'h2000_0010);
    chk("rd1_m1_ready", m1_ready_o, 1);
    chk("rd1_m0_ready", m0_ready_o, 0);
    chk("rd1_s_sel", s_sel_o, 3'b000);
    chk("rd1_s_enable", s_enable_o, 1);

    // m0 write to uart; m1 unmapped read returns zero
    cyc(); drv(1'b1, 4'hF, 32'h4000_0004, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0); #1;
    chk("rd1_m1_rvalid", m1_rvalid_o, 1);
    chk("rd1_m1_rvalue", m1_rvalue_o, 0);
    chk("rd1_m0_rvalid", m0_rvalid_o, 0);
    chk("wr0_m0_ready", m0_ready_o, 1);
    chk("wr0_s_sel", s_sel_o, 3'b100);
    chk("wr0_s_wvalue", s_wvalue_o, 32'hA0A0_A0A0);
    chk("wr0_s_wstrb", s_wstrb_o, 4'hF);

    // Idle: no requests, m0 still presented on the slave bus
    cyc(); drv(1'b0, 4'h3, 32'h1234_5678, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0); #1;
    chk("wr0_no_rvalid", {m0_rvalid_o, m1_rvalid_o}, 0);
    chk("idle_s_enable", s_enable_o, 0);
    chk("idle_s_sel", s_sel_o, 0);
    chk("idle_ready", {m0_ready_o, m1_ready_o}, 0);
    chk("idle_s_addr", s_addr_o, 32'h1234_5678);
    chk("idle_s_wstrb", s_wstrb_o, 4'h3);

    // Continuous contention from IDLE: blocks of four grants alternate
`ifdef BUS_ARB_ROUND_ROBIN_EN
    first = 1'b1;
`else
    first = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin
      cyc(); drv(1'b1, 4'hF, 32'h0000_0100, 1'b0, 1'b1, 4'hF, 32'h4000_0200, 1'b0); #1;
      exp1 = first ^ (((i / 4) % 2) == 1);
      chk($sformatf("hold_m0_ready[%0d]", i), m0_ready_o, !exp1);
      chk($sformatf("hold_m1_ready[%0d]", i), m1_ready_o, exp1);
      chk($sformatf("hold_s_enable[%0d]", i), s_enable_o, 1);
      chk($sformatf("hold_s_addr[%0d]", i), s_addr_o, exp1 ? 32'h4000_0200 : 32'h0000_0100);
    end

    cyc(); drv(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0); #1;
    chk("gap_s_enable", s_enable_o, 0);

    // m1 locked write sequence (6 cycles) overrides HOLD_MAX while m0 waits
    cyc(); drv(1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 4'hF, 32'h2000_0000, 1'b1); #1;
    chk("lock_m1_ready[0]", m1_ready_o, 1);
    for (int i = 1; i < 6; i++) begin
      cyc(); drv(1'b1, 4'hF, 32'h0000_0008, 1'b0, 1'b1, 4'hF, 32'h2000_0000 + 32'(i * 4), (i < 5)); #1;
      chk($sformatf("lock_m1_ready[%0d]", i), m1_ready_o, 1);
      chk($sformatf("lock_m0_ready[%0d]", i), m0_ready_o, 0);
    end
    // Lock has dropped and the hold count is past HOLD_MAX: m0 wins
    cyc(); drv(1'b1, 4'hF, 32'h0000_0008, 1'b0, 1'b1, 4'hF, 32'h2000_0018, 1'b0); #1;
    chk("unlock_m0_ready", m0_ready_o, 1);
    chk("unlock_m1_ready", m1_ready_o, 0);

    // Reset the cycle after an accepted read discards the read return
    cyc(); drv(1'b1, 4'h0, 32'h0000_0040, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0); #1;
    chk("rdr_m0_ready", m0_ready_o, 1);
    chk("rdr_s_sel", s_sel_o, 3'b001);
    cyc(); rstn_i = 1'b0; #1;
    chk("rdr_m0_rvalid", m0_rvalid_o, 0);
    chk("rdr_m0_rvalue", m0_rvalue_o, 0);
    chk("rdr_ready", {m0_ready_o, m1_ready_o}, 0);
    chk("rdr_s_enable", s_enable_o, 0);
    chk("rdr_s_sel", s_sel_o, 0);
    chk("rdr_addr_prev", s_addr_prev_o, 0);
    cyc(); drv(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0); rstn_i = 1'b1; #1;
    chk("rdr_post0_rvalid", {m0_rvalid_o, m1_rvalid_o}, 0);
    cyc(); #1;
    chk("rdr_post1_rvalid", {m0_rvalid_o, m1_rvalid_o}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
